// File: rtl/div_ctrl_pkg.sv
// Shared types and sizing for the multi-cycle DIV/DIVU controller.
package div_ctrl_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned IDX_W    = $clog2(DATA_W);
    localparam int unsigned PR_W     = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        ON       = 2'd2,
        DONE     = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] quot;
        logic [DATA_W-1:0] rem;
    } div_res_t;

    // Two's-complement magnitude when the operand is treated as signed
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic is_signed);
        return (is_signed && v[DATA_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring shift-subtract step on the {remainder, quotient} register.
module div_iter
    import div_ctrl_pkg::*;
(
    input  logic [PR_W-1:0]   pr_cur,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [PR_W-1:0]   pr_nxt
);

    logic [DATA_W+1:0] trial;
    logic              unused_q_msb;

    // Quotient MSB shifts out; a 32-bit quotient never sets it before the final step
    assign unused_q_msb = pr_cur[DATA_W-1];

    always_comb begin
        trial = {pr_cur[PR_W-1:DATA_W], dvd_bit} - {2'b00, divisor};
        if (!trial[DATA_W+1]) begin
            pr_nxt = {trial[DATA_W:0], pr_cur[DATA_W-2:0], 1'b1};
        end else begin
            pr_nxt = {pr_cur[PR_W-2:DATA_W], dvd_bit, pr_cur[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit for the EX stage: 32-step restoring divider with sign fix-up.
// Optional DIV_EARLY_OUT_EN: |dividend| < |divisor| completes in one cycle.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              cancel_i,
    output logic              stall_req_o,
    output logic              busy_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PR_W-1:0]   pr_q, pr_d, pr_iter;
    logic [DATA_W-1:0] dvd_mag_q, dvd_mag_d, dvs_mag_q, dvs_mag_d;
    logic              signed_q, signed_d;
    logic              dvd_neg_q, dvd_neg_d, dvs_neg_q, dvs_neg_d;
    logic              busy_q, busy_d, ready_q, ready_d;
    div_res_t          res_q, res_d, final_res;
    logic [DATA_W-1:0] dvd_abs, dvs_abs, quot_mag, rem_mag;
    logic              dvd_bit, last_iter;

    assign dvd_abs = abs_val(dividend_i, signed_i);
    assign dvs_abs = abs_val(divisor_i, signed_i);

    // Bit index 31 - cnt, i.e. dividend bits fed MSB first
    assign dvd_bit   = dvd_mag_q[~cnt_q[IDX_W-1:0]];
    assign last_iter = (cnt_q == CNT_W'(DIV_ITER - 1));

    div_iter u_iter (
        .pr_cur  (pr_q),
        .dvd_bit (dvd_bit),
        .divisor (dvs_mag_q),
        .pr_nxt  (pr_iter)
    );

    // Sign fix-up of the final iteration's magnitudes
    assign quot_mag       = pr_iter[DATA_W-1:0];
    assign rem_mag        = pr_iter[2*DATA_W-1:DATA_W];
    assign final_res.quot = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? -quot_mag : quot_mag;
    assign final_res.rem  = (signed_q && dvd_neg_q) ? -rem_mag : rem_mag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        dvd_mag_d = dvd_mag_q;
        dvs_mag_d = dvs_mag_q;
        signed_d  = signed_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        ready_d   = 1'b0;
        res_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    if (divisor_i == '0) begin
                        state_d = DIV_ZERO;
`ifdef DIV_EARLY_OUT_EN
                    end else if (dvd_abs < dvs_abs) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        res_d   = '{quot: '0, rem: dividend_i};
`endif
                    end else begin
                        state_d   = ON;
                        cnt_d     = '0;
                        pr_d      = '0;
                        dvd_mag_d = dvd_abs;
                        dvs_mag_d = dvs_abs;
                        signed_d  = signed_i;
                        dvd_neg_d = dividend_i[DATA_W-1];
                        dvs_neg_d = divisor_i[DATA_W-1];
                    end
                end
            end
            DIV_ZERO: begin
                state_d = DONE;
                ready_d = 1'b1;
            end
            ON: begin
                pr_d  = pr_iter;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    res_d   = final_res;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything, including a pending result
        if (cancel_i) begin
            state_d = IDLE;
            ready_d = 1'b0;
            res_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pr_q      <= '0;
            dvd_mag_q <= '0;
            dvs_mag_q <= '0;
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            dvd_mag_q <= dvd_mag_d;
            dvs_mag_q <= dvs_mag_d;
            signed_q  <= signed_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            res_q     <= res_d;
        end
    end

    // Stall must already be high in the issue cycle, so it decodes the live request
    assign stall_req_o = rst && ((state_q == IDLE && start_i && !cancel_i)
                                 || state_q == DIV_ZERO || state_q == ON);
    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign quot_o      = res_q.quot;
    assign rem_o       = res_q.rem;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: random and directed DIV/DIVU against an arithmetic model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, cancel_i;
    logic [31:0] dividend_i, divisor_i;
    logic        stall_req_o, busy_o, ready_o;
    logic [31:0] quot_o, rem_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          t_ready;
    } exp_t;

    exp_t sb[$];

    div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .cancel_i    (cancel_i),
        .stall_req_o (stall_req_o),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .quot_o      (quot_o),
        .rem_o       (rem_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
        longint na, nb, qq, rr;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0; lat = 2;
            return;
        end
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        qq = na / nb;
        rr = na % nb;
        q = qq[31:0];
        r = rr[31:0];
        lat = 33;
`ifdef DIV_EARLY_OUT_EN
        if ((na < 0 ? -na : na) < (nb < 0 ? -nb : nb)) lat = 1;
`endif
    endfunction

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0b want %0b at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %08h want %08h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Monitor: every result strobe is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (ready_o) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready got ready_o=1 want no result at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check32("quot", quot_o, e.q);
                    check32("rem", rem_o, e.r);
                    checks++;
                    if (cyc != e.t_ready) begin
                        errors++;
                        $display("FAIL ready_cycle got %0d want %0d", cyc, e.t_ready);
                    end
                end
            end else begin
                check32("quot_idle", quot_o, 32'd0);
                check32("rem_idle", rem_o, 32'd0);
            end
        end
    end

    // Issue one request, hold start_i through the stall, drop it after the result cycle
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   t0, lat;
        logic got;
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
        t0 = cyc;
        model(sgn, a, b, e.q, e.r, lat);
        e.t_ready = t0 + lat;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            check1("stall", stall_req_o, cyc < e.t_ready);
            check1("busy", busy_o, cyc > t0);
            if (ready_o) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout got no ready_o want ready at cycle %0d", e.t_ready);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_stall"}, stall_req_o, 1'b0);
        check1({tag, "_busy"}, busy_o, 1'b0);
        check1({tag, "_ready"}, ready_o, 1'b0);
        check32({tag, "_quot"}, quot_o, 32'd0);
        check32({tag, "_rem"}, rem_o, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          t0;

        rst = 1'b0; start_i = 1'b1; signed_i = 1'b0; cancel_i = 1'b0;
        dividend_i = 32'd100; divisor_i = 32'd7;
        #1;
        check_all_zero("reset");
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Directed corner cases
        run_op(1'b0, 32'd100, 32'd7);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'd5, 32'd0);
        run_op(1'b0, 32'd5, 32'd9);
        run_op(1'b1, 32'hFFFF_FFFB, 32'd9);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1);

        // Start blocked by a simultaneous flush
        @(posedge clk); #1;
        start_i = 1'b1; cancel_i = 1'b1; divisor_i = 32'd3;
        @(negedge clk);
        check1("cancel_blocks_stall", stall_req_o, 1'b0);
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        @(negedge clk);
        check1("cancel_blocks_busy", busy_o, 1'b0);

        // Flush at T10, restart at T12
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
        t0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        check1("cancel_at_t10", (cyc == t0 + 10) ? 1'b1 : 1'b0, 1'b1);
        cancel_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        @(negedge clk);
        check1("t11_stall", stall_req_o, 1'b0);
        check1("t11_busy", busy_o, 1'b0);
        run_op(1'b0, 32'd1000, 32'd3);

        // Reset in the middle of an operation
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'h1234_5678; divisor_i = 32'd5;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0; start_i = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check1("after_reset_busy", busy_o, 1'b0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 40));
                default: a = $urandom;
            endcase
            run_op(s, a, b);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got no finish want finish by 1000000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset: asynchronous and active-low.
REQ-003 SHALL have port start_i, input, 1, EX-stage DIV/DIVU request, held high while the instruction is stalled in EX.
REQ-004 SHALL have port signed_i, input, 1: 1 = DIV, 0 = DIVU; sampled with start_i.
REQ-005 SHALL have ports dividend_i and divisor_i, input, 32 each, operands; sampled with start_i.
REQ-006 SHALL have port cancel_i, input, 1, pipeline flush; aborts any operation.
REQ-007 SHALL have port stall_req_o, output, 1, pipeline stall request.
REQ-008 SHALL have port busy_o, output, 1: high in any non-IDLE state.
REQ-009 SHALL have port ready_o, output, 1, one-cycle result-valid strobe.
REQ-010 SHALL have ports quot_o (LO value) and rem_o (HI value), output, 32 each; valid only while ready_o = 1.

Function
REQ-011 SHALL implement FSM states IDLE, DIV_ZERO, ON, DONE.
REQ-012 IDLE transitions: start_i=1, cancel_i=0, divisor_i=0 -> DIV_ZERO; start_i=1, cancel_i=0, divisor_i!=0 -> ON; otherwise stay IDLE.
REQ-013 On IDLE->ON, SHALL latch operand magnitudes (two's-complement absolute value when signed_i=1), signs and signed_i, clear the 6-bit iteration counter and clear the 65-bit partial remainder/quotient register.
REQ-014 ON SHALL perform one restoring shift-subtract iteration per cycle for exactly 32 cycles, then go to DONE.
REQ-015 Start edge T0 SHALL yield ready_o=1 during cycle T33.
REQ-016 DIV_ZERO SHALL last one cycle, then go to DONE with quot_o = 0 and rem_o = 0.
REQ-017 DONE SHALL last one cycle with ready_o = 1, then go to IDLE; start_i is ignored in DONE.
REQ-018 Signed correction in DONE: quotient negated when operand signs differ; remainder takes the sign of the dividend.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give quot_o = 0x80000000, rem_o = 0 (wrap, no trap).
REQ-020 stall_req_o SHALL be 1 when (IDLE and start_i and not cancel_i) or state is DIV_ZERO or ON; it SHALL be 0 in DONE so the pipeline advances and captures the result.
REQ-021 cancel_i=1 in any state SHALL force IDLE on the next edge, with no ready_o for the aborted operation; cancel_i takes priority over start_i.
REQ-022 quot_o and rem_o SHALL be 0 whenever ready_o = 0.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, clear counter and datapath registers, and drive stall_req_o, busy_o, ready_o, quot_o and rem_o to 0.
REQ-024 Reset asserted mid-operation SHALL discard the operation; no ready_o after release.

Configuration
REQ-025 Macro DIV_EARLY_OUT_EN, when defined: IDLE start with |dividend| < |divisor| (divisor nonzero) SHALL go directly to DONE with quotient 0 and remainder = dividend_i (original sign), ready_o at T1.
REQ-026 When DIV_EARLY_OUT_EN is not defined, every nonzero-divisor operation SHALL take the full 32 iterations per REQ-015.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, DIV_ITER = 32, and the counter width constant.
REQ-028 A combinational sub-module div_iter SHALL implement one restoring iteration (65-bit in, 65-bit out); the counter and FSM stay in div_ctrl.

Verification
REQ-029 DIVU 100/7 at T0 -> stall_req_o high T0..T32; ready_o at T33 with quot_o = 14, rem_o = 2.
REQ-030 DIV -7/2 -> quot_o = 0xFFFFFFFD, rem_o = 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> quot_o = 0x80000000, rem_o = 0.
REQ-031 DIVU 5/0 -> DIV_ZERO at T1, ready_o at T2 with quot_o = 0, rem_o = 0.
REQ-032 cancel_i pulsed at T10 of a DIVU -> IDLE at T11; stall_req_o low from T11; no ready_o; a new start at T12 completes normally at T45.
REQ-033 rst low at T15 of an operation -> all outputs 0 immediately; after release, no ready_o for the old operation.
REQ-034 With DIV_EARLY_OUT_EN defined, DIVU 5/9 -> ready_o at T1 with quot_o = 0, rem_o = 5; without the macro -> ready_o at T33 with the same values.
